z80_ld_ind_nn_a_seq: RTL and testbench
======================================

# z80_ld_ind_nn_a_seq

Bus-cycle sequencer that executes `LD (nn),A` (opcode 0x32) on the Z80 external bus. It runs the opcode fetch, the two operand reads, and the memory write, with wait-state handshaking on each. At retirement it emits a Z80FI retirement record that the `LD (nn),A` instruction spec checks. It sits between the core's dispatch logic and the memory bus interface.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin an instruction. Sampled only in IDLE.
- `ip_in` in 16: address of the opcode byte.
- `reg_a_in` in 8: register A value, captured when `start` is accepted.
- `bus_addr` out 16: address bus.
- `bus_din` in 8: read data.
- `bus_dout` out 8: write data.
- `mreq_n`, `rd_n`, `wr_n`, `m1_n` out 1 each: active-low bus strobes.
- `wait_n` in 1: active-low wait request, sampled in T2.
- `busy` out 1: high in every state except IDLE.
- `z80fi_valid` out 1: one-cycle retirement strobe.
- `z80fi_insn` out 32: `{8'h00, nn_hi, nn_lo, opcode}`; unused bytes are 0.
- `z80fi_insn_len` out 4: 3 for 0x32, 1 for illegal.
- `z80fi_mem_waddr` out 16, `z80fi_mem_wdata` out 8: write address and data (0 if illegal).
- `z80fi_reg_ip_out` out 16: `ip_in + insn_len`, mod 2^16.
- `illegal` out 1: qualifies `z80fi_valid`; set when the opcode is not 0x32.

## Operation
- **States:** IDLE, F_T1, F_T2, F_T3, F_T4, R_T1, R_T2, R_T3, W_T1, W_T2, W_T3, RETIRE. A 1-bit `byte_sel` selects lo/hi for the R states.
- **IDLE:** when `start`=1, latch `ip_in` into `ip` and `reg_a_in` into `a`; go to F_T1.
- **Opcode fetch:**
  - `bus_addr`=`ip` in F_T1–F_T4.
  - `m1_n`, `mreq_n`, `rd_n` low in F_T1 and F_T2.
  - Opcode latched from `bus_din` on the edge leaving F_T2.
  - F_T3 and F_T4 are idle bus cycles with all strobes high; refresh is not modeled.
  - After F_T4: if opcode=0x32 go to R_T1 with `byte_sel`=0; otherwise go to RETIRE with `illegal`=1.
- **Operand read:**
  - `bus_addr`=`ip+1+byte_sel`.
  - `mreq_n`, `rd_n` low in R_T1 and R_T2.
  - Data latched into `nn_lo` or `nn_hi` leaving R_T2.
  - R_T3 with `byte_sel`=0 goes to R_T1 with `byte_sel`=1; with `byte_sel`=1 it goes to W_T1.
- **Memory write:**
  - `bus_addr`={`nn_hi`,`nn_lo`}; `bus_dout`=`a` in W_T1–W_T3.
  - `mreq_n` low in W_T1–W_T3; `wr_n` low in W_T2 only.
  - W_T3 goes to RETIRE.
- **Wait states:** in any `*_T2`, if `wait_n`=0 at the edge, stay in T2 with strobes held. Each waited cycle adds exactly one clock.
- **RETIRE:**
  - `z80fi_valid`=1 for one cycle, and all z80fi outputs are valid in that cycle.
  - Next state is IDLE.
  - `start` in RETIRE is ignored; `start` is never queued.
- **Address arithmetic:** wraps mod 2^16 (`ip`=0xFFFF reads operands at 0x0000 and 0x0001).
- **Reset:**
  - At any state, including mid-bus-cycle, reset forces IDLE in the next cycle.
  - `mreq_n`/`rd_n`/`wr_n`/`m1_n`=1; `busy`=0; `z80fi_valid`=0; `illegal`=0.
  - `bus_addr`, `bus_dout`, `z80fi_*` data outputs = 0.
  - No retirement is emitted for the aborted instruction.

## Timing
- Strobes and `bus_addr` are registered, so they change only on `clk` edges.
- With no waits, `start` accepted at edge k gives:
  - F_T1 at k+1;
  - R_T1 (lo) at k+5;
  - R_T1 (hi) at k+8;
  - W_T1 at k+11;
  - RETIRE, with `z80fi_valid` high, at k+14.
- Each waited T2 cycle shifts all later events by +1.
- Illegal opcode: RETIRE at k+5.
- Back-to-back instructions: the earliest next `start` is accepted in the IDLE cycle at k+15.
- `busy` rises at k+1 and falls when IDLE is re-entered.

## Test plan
- **Nominal, no waits:** `ip`=0x1000, memory [0x1000..0x1002]=32 34 12, A=0x5A. Expect:
  - `wr_n` low exactly 1 cycle with `bus_addr`=0x1234, `bus_dout`=0x5A;
  - `z80fi_valid` at k+14 with `insn`=0x00123432, `len`=3, `ip_out`=0x1003, `waddr`=0x1234, `wdata`=0x5A.
- **Wait states:** same stimulus, `wait_n` low for 2 cycles in the first R_T2 and 1 cycle in W_T2. Expect RETIRE at k+17 and identical record.
- **Wrap:** `ip`=0xFFFF, mem[0xFFFF]=0x32, mem[0x0000]=0xCD, mem[0x0001]=0xAB. Expect operand reads at 0x0000 and 0x0001, write to 0xABCD, `ip_out`=0x0002.
- **Illegal opcode:** opcode 0x3A. Expect no R/W cycles; RETIRE at k+5 with `illegal`=1, `len`=1, `insn`=0x0000003A, `ip_out`=`ip`+1.
- **Reset mid-op:** assert `reset` during W_T2. Expect next cycle IDLE, all strobes high, `busy`=0, no `z80fi_valid`; a subsequent `start` completes normally.
- **Start while busy:** pulse `start` at k+3 and in RETIRE. Expect both ignored, with exactly one retirement.

Source files
------------

// File: rtl/z80_ld_ind_nn_a_seq.sv
// Bus-cycle sequencer for Z80 LD (nn),A: opcode fetch, two operand reads, one memory write,
// with wait states in every T2 and a Z80FI retirement record in the RETIRE cycle.
module z80_ld_ind_nn_a_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ip_in,
    input  logic [7:0]  reg_a_in,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        mreq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        m1_n,
    input  logic        wait_n,
    output logic        busy,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [3:0]  z80fi_insn_len,
    output logic [15:0] z80fi_mem_waddr,
    output logic [7:0]  z80fi_mem_wdata,
    output logic [15:0] z80fi_reg_ip_out,
    output logic        illegal,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        F_T1   = 4'd1,
        F_T2   = 4'd2,
        F_T3   = 4'd3,
        F_T4   = 4'd4,
        R_T1   = 4'd5,
        R_T2   = 4'd6,
        R_T3   = 4'd7,
        W_T1   = 4'd8,
        W_T2   = 4'd9,
        W_T3   = 4'd10,
        RETIRE = 4'd11
    } state_t;

    state_t      state, state_d;
    logic [15:0] ip, ip_d;
    logic [7:0]  a, a_d;
    logic [7:0]  opcode, op_d;
    logic [7:0]  nn_lo, lo_d;
    logic [7:0]  nn_hi, hi_d;
    logic        byte_sel, sel_d;
    logic        illegal_q, ill_d;

    logic [15:0] rd_addr_d;
    logic [15:0] addr_d;
    logic [7:0]  dout_d;
    logic        mreq_d, rd_d, wr_d, m1_d;

    // Handshake: start is a request qualified only while IDLE (busy=0); it is accepted on the
    // edge where start=1 and busy=0, and is never queued. Any other cycle drops it.
    always_comb begin
        state_d = state;
        ip_d    = ip;
        a_d     = a;
        op_d    = opcode;
        lo_d    = nn_lo;
        hi_d    = nn_hi;
        sel_d   = byte_sel;
        ill_d   = illegal_q;
        case (state)
            IDLE: begin
                if (start) begin
                    ip_d    = ip_in;
                    a_d     = reg_a_in;
                    op_d    = 8'h00;
                    lo_d    = 8'h00;
                    hi_d    = 8'h00;
                    sel_d   = 1'b0;
                    ill_d   = 1'b0;
                    state_d = F_T1;
                end
            end
            F_T1: state_d = F_T2;
            F_T2: begin
                if (wait_n) begin
                    op_d    = bus_din;
                    state_d = F_T3;
                end
            end
            F_T3: state_d = F_T4;
            F_T4: begin
                if (opcode == 8'h32) begin
                    sel_d   = 1'b0;
                    state_d = R_T1;
                end else begin
                    ill_d   = 1'b1;
                    state_d = RETIRE;
                end
            end
            R_T1: state_d = R_T2;
            R_T2: begin
                if (wait_n) begin
                    if (byte_sel) hi_d = bus_din;
                    else          lo_d = bus_din;
                    state_d = R_T3;
                end
            end
            R_T3: begin
                if (!byte_sel) begin
                    sel_d   = 1'b1;
                    state_d = R_T1;
                end else begin
                    state_d = W_T1;
                end
            end
            W_T1: state_d = W_T2;
            W_T2: if (wait_n) state_d = W_T3;
            W_T3: state_d = RETIRE;
            RETIRE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr_d = ip_d + 16'd1 + {15'd0, sel_d};

    // Bus outputs are decoded from the next state so they can be registered in step with it.
    always_comb begin
        addr_d = 16'h0000;
        dout_d = 8'h00;
        mreq_d = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        m1_d   = 1'b1;
        case (state_d)
            F_T1, F_T2: begin
                addr_d = ip_d;
                m1_d   = 1'b0;
                mreq_d = 1'b0;
                rd_d   = 1'b0;
            end
            F_T3, F_T4: addr_d = ip_d;
            R_T1, R_T2: begin
                addr_d = rd_addr_d;
                mreq_d = 1'b0;
                rd_d   = 1'b0;
            end
            R_T3: addr_d = rd_addr_d;
            W_T1, W_T3: begin
                addr_d = {hi_d, lo_d};
                dout_d = a_d;
                mreq_d = 1'b0;
            end
            W_T2: begin
                addr_d = {hi_d, lo_d};
                dout_d = a_d;
                mreq_d = 1'b0;
                wr_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ip        <= 16'h0000;
            a         <= 8'h00;
            opcode    <= 8'h00;
            nn_lo     <= 8'h00;
            nn_hi     <= 8'h00;
            byte_sel  <= 1'b0;
            illegal_q <= 1'b0;
            bus_addr  <= 16'h0000;
            bus_dout  <= 8'h00;
            mreq_n    <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            m1_n      <= 1'b1;
        end else begin
            state     <= state_d;
            ip        <= ip_d;
            a         <= a_d;
            opcode    <= op_d;
            nn_lo     <= lo_d;
            nn_hi     <= hi_d;
            byte_sel  <= sel_d;
            illegal_q <= ill_d;
            bus_addr  <= addr_d;
            bus_dout  <= dout_d;
            mreq_n    <= mreq_d;
            rd_n      <= rd_d;
            wr_n      <= wr_d;
            m1_n      <= m1_d;
        end
    end

    logic       retire;
    logic [3:0] insn_len;

    assign retire   = (state == RETIRE);
    assign insn_len = illegal_q ? 4'd1 : 4'd3;

    // The retirement record is driven only during RETIRE and reads as zero otherwise.
    assign busy             = (state != IDLE);
    assign z80fi_valid      = retire;
    assign illegal          = retire && illegal_q;
    assign z80fi_insn       = retire ? {8'h00, nn_hi, nn_lo, opcode} : 32'h0;
    assign z80fi_insn_len   = retire ? insn_len : 4'd0;
    assign z80fi_mem_waddr  = (retire && !illegal_q) ? {nn_hi, nn_lo} : 16'h0000;
    assign z80fi_mem_wdata  = (retire && !illegal_q) ? a : 8'h00;
    assign z80fi_reg_ip_out = retire ? (ip + {12'd0, insn_len}) : 16'h0000;
    assign dbg_state        = state;

endmodule

// File: tb/tb_z80_ld_ind_nn_a_seq.sv
// Bench for z80_ld_ind_nn_a_seq: memory model on the bus, wait-state driver keyed on strobes,
// read-address scoreboard and a per-instruction reference model of the retirement record.
module tb_z80_ld_ind_nn_a_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] ip_in;
  logic [7:0]  reg_a_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;
  logic        mreq_n, rd_n, wr_n, m1_n;
  logic        wait_n;
  logic        busy;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [3:0]  z80fi_insn_len;
  logic [15:0] z80fi_mem_waddr;
  logic [7:0]  z80fi_mem_wdata;
  logic [15:0] z80fi_reg_ip_out;
  logic        illegal;
  logic [3:0]  dbg_state;

  z80_ld_ind_nn_a_seq dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .ip_in            (ip_in),
    .reg_a_in         (reg_a_in),
    .bus_addr         (bus_addr),
    .bus_din          (bus_din),
    .bus_dout         (bus_dout),
    .mreq_n           (mreq_n),
    .rd_n             (rd_n),
    .wr_n             (wr_n),
    .m1_n             (m1_n),
    .wait_n           (wait_n),
    .busy             (busy),
    .z80fi_valid      (z80fi_valid),
    .z80fi_insn       (z80fi_insn),
    .z80fi_insn_len   (z80fi_insn_len),
    .z80fi_mem_waddr  (z80fi_mem_waddr),
    .z80fi_mem_wdata  (z80fi_mem_wdata),
    .z80fi_reg_ip_out (z80fi_reg_ip_out),
    .illegal          (illegal),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign bus_din = mem[bus_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard of expected read bus-cycle addresses
  logic [15:0] exp_q[$];

  // wait plan per bus cycle: 0 fetch, 1 operand lo, 2 operand hi, 3 write
  int plan [4];
  int bc = 0;
  int waited = 0;
  int rd_run = 0;
  bit was_t2 = 1'b0;
  int wr_cycles = 0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;

  // bus monitor and wait-state driver
  always @(negedge clk) begin
    bit rd_low;
    bit in_t2;
    if (reset) begin
      rd_run = 0;
      was_t2 = 1'b0;
      wait_n = 1'b1;
    end else begin
      rd_low = !mreq_n && !rd_n;
      if (rd_low && rd_run == 0) begin
        if (exp_q.size() == 0) check("rd_unexpected", {16'h0, bus_addr}, 32'hFFFF_FFFF);
        else check("rd_addr", {16'h0, bus_addr}, {16'h0, exp_q.pop_front()});
      end
      in_t2  = (rd_low && rd_run >= 1) || (!mreq_n && !wr_n);
      rd_run = rd_low ? rd_run + 1 : 0;
      if (!mreq_n && !wr_n) begin
        wr_cycles++;
        wr_addr = bus_addr;
        wr_data = bus_dout;
      end
      if (in_t2) begin
        if (bc < 4 && waited < plan[bc]) begin
          wait_n = 1'b0;
          waited++;
        end else begin
          wait_n = 1'b1;
        end
      end else begin
        wait_n = 1'b1;
        if (was_t2) begin
          bc++;
          waited = 0;
        end
      end
      was_t2 = in_t2;
    end
  end

  // driver: one LD (nn),A attempt, with the record derived from the memory image
  task automatic run_insn(input logic [15:0] ip, input logic [7:0] a,
                          input int w0, input int w1, input int w2, input int w3,
                          input bit extra_start);
    logic [7:0]  op;
    logic [15:0] ip1, ip2;
    logic [15:0] nn;
    bit          legal;
    int          exp_lat;
    int          lat;
    ip1 = ip + 16'd1;
    ip2 = ip + 16'd2;
    op = mem[ip];
    legal = (op == 8'h32);
    nn = {mem[ip2], mem[ip1]};
    exp_lat = legal ? 14 + w0 + w1 + w2 + w3 : 5 + w0;
    exp_q.delete();
    exp_q.push_back(ip);
    if (legal) begin
      exp_q.push_back(ip1);
      exp_q.push_back(ip2);
    end
    @(negedge clk);
    plan[0] = w0; plan[1] = w1; plan[2] = w2; plan[3] = w3;
    bc = 0;
    waited = 0;
    wr_cycles = 0;
    check("idle_before", {31'd0, busy}, 32'd0);
    start = 1'b1;
    ip_in = ip;
    reg_a_in = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ip_in = $urandom;
    reg_a_in = $urandom;
    lat = 1;
    check("busy_rise", {31'd0, busy}, 32'd1);
    while (!z80fi_valid && lat < 60) begin
      @(negedge clk);
      lat++;
      start = extra_start && (lat == 3);
    end
    if (extra_start) start = 1'b1;
    check("retire_cycle", lat, exp_lat);
    check("valid", {31'd0, z80fi_valid}, 32'd1);
    check("insn", z80fi_insn, legal ? {8'h00, nn, op} : {24'h0, op});
    check("len", {28'd0, z80fi_insn_len}, legal ? 32'd3 : 32'd1);
    check("ip_out", {16'h0, z80fi_reg_ip_out}, {16'h0, legal ? ip + 16'd3 : ip + 16'd1});
    check("waddr", {16'h0, z80fi_mem_waddr}, legal ? {16'h0, nn} : 32'd0);
    check("wdata", {24'h0, z80fi_mem_wdata}, legal ? {24'h0, a} : 32'd0);
    check("illegal", {31'd0, illegal}, {31'd0, !legal});
    check("wr_cycles", wr_cycles, legal ? 1 + w3 : 0);
    if (legal) begin
      check("wr_addr", {16'h0, wr_addr}, {16'h0, nn});
      check("wr_data", {24'h0, wr_data}, {24'h0, a});
    end
    check("reads_done", exp_q.size(), 0);
    @(negedge clk);
    start = 1'b0;
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("valid_once", {31'd0, z80fi_valid}, 32'd0);
    @(negedge clk);
    check("no_restart", {31'd0, busy}, 32'd0);
  endtask

  task automatic load(input logic [15:0] ip, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2);
    logic [15:0] p;
    p = ip;
    mem[p] = b0;
    p = p + 16'd1;
    mem[p] = b1;
    p = p + 16'd1;
    mem[p] = b2;
  endtask

  initial begin
    int seen_valid;
    int cnt;
    reset = 1'b1;
    start = 1'b0;
    ip_in = '0;
    reg_a_in = '0;
    wait_n = 1'b1;
    plan[0] = 0; plan[1] = 0; plan[2] = 0; plan[3] = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {28'd0, mreq_n, rd_n, wr_n, m1_n}, 32'hF);
    check("rst_valid", {31'd0, z80fi_valid}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_addr", {16'h0, bus_addr}, 32'd0);
    check("rst_insn", z80fi_insn, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // nominal
    load(16'h1000, 8'h32, 8'h34, 8'h12);
    run_insn(16'h1000, 8'h5A, 0, 0, 0, 0, 1'b0);
    // wait states: 2 in first operand T2, 1 in write T2
    run_insn(16'h1000, 8'h5A, 0, 2, 0, 1, 1'b0);
    // address wrap
    load(16'hFFFF, 8'h32, 8'hCD, 8'hAB);
    run_insn(16'hFFFF, 8'h77, 0, 0, 0, 0, 1'b0);
    // illegal opcode
    load(16'h2000, 8'h3A, 8'h11, 8'h22);
    run_insn(16'h2000, 8'h99, 0, 0, 0, 0, 1'b0);
    // start while busy and in RETIRE
    load(16'h3000, 8'h32, 8'h00, 8'h40);
    run_insn(16'h3000, 8'hC3, 1, 0, 1, 0, 1'b1);

    // reset during W_T2
    load(16'h4000, 8'h32, 8'h78, 8'h56);
    exp_q.delete();
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h4001);
    exp_q.push_back(16'h4002);
    plan[0] = 0; plan[1] = 0; plan[2] = 0; plan[3] = 0;
    bc = 0;
    waited = 0;
    @(negedge clk);
    start = 1'b1;
    ip_in = 16'h4000;
    reg_a_in = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (wr_n && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_w_t2", {31'd0, wr_n}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_strobes", {28'd0, mreq_n, rd_n, wr_n, m1_n}, 32'hF);
    check("abort_valid", {31'd0, z80fi_valid}, 32'd0);
    check("abort_addr", {16'h0, bus_addr}, 32'd0);
    check("abort_dout", {24'h0, bus_dout}, 32'd0);
    reset = 1'b0;
    bc = 0;
    waited = 0;
    seen_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (z80fi_valid || busy) seen_valid++;
    end
    check("abort_no_retire", seen_valid, 0);
    run_insn(16'h4000, 8'h3C, 0, 1, 1, 0, 1'b0);

    // randomized instructions
    for (int i = 0; i < 25; i++) begin
      logic [15:0] rip;
      logic [7:0]  rop;
      rip = $urandom;
      rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h32;
      load(rip, rop, 8'($urandom), 8'($urandom));
      run_insn(rip, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
